// File: rtl/eeprom_uart_logger_if.sv
// Byte-in / UART-out bundle between the AT24 read driver and the hex logger.
`timescale 1ns/1ps
interface eeprom_uart_logger_if;
    logic       data_valid;
    logic [7:0] data_in;
    logic       uart_tx;
    logic       busy;
    logic       overflow;
    logic [7:0] msg_cnt;

    modport master (
        output data_valid, data_in,
        input  uart_tx, busy, overflow, msg_cnt
    );

    modport slave (
        input  data_valid, data_in,
        output uart_tx, busy, overflow, msg_cnt
    );
endinterface

// File: rtl/eeprom_uart_logger.sv
// Formats each EEPROM read byte as "HH\r\n" and shifts it out an 8N1 UART pin.
`timescale 1ns/1ps
module eeprom_uart_logger #(
    parameter int BAUD_DIV = 104
) (
    input  logic              clk,
    input  logic              rst_n,
    eeprom_uart_logger_if.slave bus
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // vld_pipe[0..1] synchronize the driver's valid, [2] is the edge-detect delay
    logic [2:0] vld_pipe;
    logic       new_pulse;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    char_idx;
    logic [7:0]    byte_reg;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic          overflow_r;
    logic          tx_r;
    logic [7:0]    msg_cnt_r;

    logic          baud_end;
    logic          rec_end;
    logic          load;
    logic [7:0]    cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[1:0], bus.data_valid};
    end

    assign new_pulse = vld_pipe[1] & ~vld_pipe[2];

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign rec_end  = (state == STOP) && baud_end && (char_idx == 2'd3);
    assign load     = hold_full && ((state == IDLE) || rec_end);

    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            2'd0:    cur_char = hex_ascii(byte_reg[7:4]);
            2'd1:    cur_char = hex_ascii(byte_reg[3:0]);
            2'd2:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    // Single-entry hold; a same-cycle load frees the slot for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            overflow_r <= 1'b0;
        end else if (new_pulse) begin
            if (!hold_full || load) begin
                hold_data <= bus.data_in;
                hold_full <= 1'b1;
            end else begin
                overflow_r <= 1'b1;
            end
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // tx_r is registered alongside the state so the pin changes on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            char_idx  <= '0;
            byte_reg  <= '0;
            tx_r      <= 1'b1;
            msg_cnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (load) begin
                        byte_reg <= hold_data;
                        char_idx <= 2'd0;
                        baud_cnt <= '0;
                        state    <= START;
                        tx_r     <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        tx_r     <= cur_char[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_r    <= cur_char[3'(bit_idx + 3'd1)];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (char_idx != 2'd3) begin
                            char_idx <= char_idx + 2'd1;
                            state    <= START;
                            tx_r     <= 1'b0;
                        end else begin
                            msg_cnt_r <= msg_cnt_r + 8'd1;
                            if (load) begin
                                byte_reg <= hold_data;
                                char_idx <= 2'd0;
                                state    <= START;
                                tx_r     <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx_r  <= 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.uart_tx  = tx_r;
    assign bus.busy     = (state != IDLE) | hold_full;
    assign bus.overflow = overflow_r;
    assign bus.msg_cnt  = msg_cnt_r;
endmodule

// File: tb/tb_eeprom_uart_logger.sv
// Bench for eeprom_uart_logger: UART decoder monitor plus a text-level record model.
`timescale 1ns/1ps
module tb_eeprom_uart_logger;
    localparam int BD = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    eeprom_uart_logger_if bus();

    eeprom_uart_logger #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int start_cyc[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART receiver: samples mid-bit, drops anything in flight on reset
    initial begin : mon
        logic prev;
        logic rx_on;
        int cnt;
        int k;
        logic [7:0] sh;
        prev = 1'b1; rx_on = 1'b0; cnt = 0; sh = '0; k = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_on = 1'b0;
                prev  = 1'b1;
            end else if (!rx_on) begin
                if (prev && !bus.uart_tx) begin
                    rx_on = 1'b1;
                    cnt   = 0;
                    start_cyc.push_back(cyc);
                end
                prev = bus.uart_tx;
            end else begin
                cnt++;
                if (cnt % BD == BD / 2) begin
                    k = cnt / BD;
                    if (k == 0) begin
                        if (bus.uart_tx) begin frame_err++; rx_on = 1'b0; end
                    end else if (k <= 8) begin
                        sh[k-1] = bus.uart_tx;
                    end else begin
                        if (bus.uart_tx) rx_q.push_back(sh);
                        else             frame_err++;
                        rx_on = 1'b0;
                    end
                end
                prev = bus.uart_tx;
            end
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        int v;
        v = n;
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(hexc(b[7:4]));
        exp_q.push_back(hexc(b[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_rx(input string nm);
        logic [7:0] a, e;
        chk({nm, " rx count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, " char"}, a, e);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int t;
        t = 0;
        while (bus.busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for idle after %0d cycles, required < %0d", nm, t, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rx(input string nm, input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout, got %0d chars required %0d", nm, rx_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete(); exp_q.delete(); start_cyc.delete();
        @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] rb;
        int exp_msgs;

        vecs[0] = '{8'h00, "0", "0"};
        vecs[1] = '{8'hFF, "F", "F"};
        vecs[2] = '{8'h9A, "9", "A"};
        vecs[3] = '{8'h3C, "3", "C"};
        vecs[4] = '{8'hA5, "A", "5"};
        vecs[5] = '{8'h5A, "5", "A"};

        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset uart_tx", bus.uart_tx, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset overflow", bus.overflow, 0);
        chk("reset msg_cnt", bus.msg_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // start latency and exact record length
        bus.data_in    = 8'h3C;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat N+1 busy", bus.busy, 0);
        @(posedge clk); #1;
        chk("lat N+2 busy", bus.busy, 1);
        chk("lat N+2 tx", bus.uart_tx, 1);
        @(posedge clk); #1;
        chk("lat N+3 tx", bus.uart_tx, 0);
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (40 * BD - 1) @(posedge clk);
        #1;
        chk("len pre msg_cnt", bus.msg_cnt, 0);
        chk("len pre busy", bus.busy, 1);
        @(posedge clk); #1;
        chk("len end msg_cnt", bus.msg_cnt, 1);
        chk("len end busy", bus.busy, 0);
        push_exp(8'h3C);
        check_rx("basic 3C");
        exp_msgs = 1;

        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].din, 3);
            wait_idle("table", 2000);
            exp_q.push_back(vecs[i].c0);
            exp_q.push_back(vecs[i].c1);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            check_rx($sformatf("table %02h", vecs[i].din));
            exp_msgs++;
            chk("table msg_cnt", bus.msg_cnt, exp_msgs);
        end

        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            push_exp(rb);
            send_byte(rb, $urandom_range(3, 20));
            wait_idle("random", 2000);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            check_rx($sformatf("random %02h", rb));
            exp_msgs++;
            chk("random msg_cnt", bus.msg_cnt, exp_msgs);
        end

        // level held high gives exactly one record
        do_reset();
        bus.data_in    = 8'hA5;
        bus.data_valid = 1'b1;
        repeat (2000) @(negedge clk);
        bus.data_valid = 1'b0;
        wait_idle("level", 2000);
        push_exp(8'hA5);
        check_rx("level A5");
        chk("level msg_cnt", bus.msg_cnt, 1);
        chk("level overflow", bus.overflow, 0);

        // pending byte chained without gap, third byte dropped
        do_reset();
        send_byte(8'hA5, 3);
        repeat (30) @(negedge clk);
        send_byte(8'h5A, 3);
        repeat (20) @(negedge clk);
        send_byte(8'h00, 3);
        wait_idle("pending", 3000);
        push_exp(8'hA5);
        push_exp(8'h5A);
        chk("pending starts", start_cyc.size(), 8);
        if (start_cyc.size() >= 5)
            chk("pending no gap", start_cyc[4] - start_cyc[0], 40 * BD);
        check_rx("pending");
        chk("pending overflow", bus.overflow, 1);
        chk("pending msg_cnt", bus.msg_cnt, 2);

        // reset mid DATA of char 1
        send_byte(8'h3C, 3);
        wait_rx("midrst", 1, 2000);
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst tx", bus.uart_tx, 1);
        chk("midrst busy", bus.busy, 0);
        chk("midrst overflow", bus.overflow, 0);
        chk("midrst msg_cnt", bus.msg_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete(); exp_q.delete(); start_cyc.delete();
        repeat (5 * BD) @(negedge clk);
        chk("post rst tx", bus.uart_tx, 1);
        chk("post rst busy", bus.busy, 0);
        send_byte(8'h12, 3);
        wait_idle("post rst", 2000);
        push_exp(8'h12);
        check_rx("post rst 12");
        chk("post rst msg_cnt", bus.msg_cnt, 1);

        // message counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rb = 8'($urandom_range(0, 255));
            push_exp(rb);
            send_byte(rb, 3);
            wait_idle("wrap", 2000);
            if (i == 254) chk("wrap msg_cnt 255", bus.msg_cnt, 255);
        end
        chk("wrap msg_cnt 0", bus.msg_cnt, 0);
        chk("wrap overflow", bus.overflow, 0);
        check_rx("wrap stream");

        chk("frame errors", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
